// File: rtl/dcache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between the
// MEM stage and the SRAM controller. Read misses fetch a two-word line.
module dcache_controller #(
    parameter int BASE_ADDR = 1024,
    parameter int INDEX_W   = 6,
    parameter int TAG_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] Data_address,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic        freeze_signal,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int SETS = 1 << INDEX_W;
    localparam int HI = INDEX_W + TAG_W + 2;
    localparam logic [31:0] BASE = BASE_ADDR;

    typedef enum logic [2:0] {IDLE, RD0, RD1, FILL, WR} state_t;

    state_t state;

    logic [HI:2]         dec;
    logic                word_sel;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic [31:0]         line_base;

    logic [SETS-1:0]     valid0;
    logic [SETS-1:0]     valid1;
    logic [SETS-1:0]     lru;
    logic [TAG_W-1:0]    tag_mem [2][SETS];
    logic [31:0]         w0_mem  [2][SETS];
    logic [31:0]         w1_mem  [2][SETS];

    logic [31:0]         fill_word0;
    logic [31:0]         fill_word1;

    logic                hit0;
    logic                hit1;
    logic                hit;
    logic                hit_way;
    logic [31:0]         hit_word;
    logic                victim;

    // Bits [1:0] never matter, so the decode subtracts on the word address only.
    assign dec       = Data_address[HI:2] - BASE[HI:2];
    assign word_sel  = dec[2];
    assign index     = dec[INDEX_W+2:3];
    assign tag       = dec[HI:INDEX_W+3];
    assign line_base = {Data_address[31:3], 3'b000};

    assign hit0     = valid0[index] && (tag_mem[0][index] == tag);
    assign hit1     = valid1[index] && (tag_mem[1][index] == tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = hit1;
    assign hit_word = word_sel ? w1_mem[hit_way][index] : w0_mem[hit_way][index];
    assign victim   = !valid0[index] ? 1'b0 : (!valid1[index] ? 1'b1 : ~lru[index]);

    always_comb begin
        freeze_signal = 1'b0;
        Data_out      = '0;
        unique case (state)
            IDLE: begin
                if (MEM_W_EN) begin
                    freeze_signal = 1'b1;
                end else if (MEM_R_EN) begin
                    if (hit) Data_out = hit_word;
                    else     freeze_signal = 1'b1;
                end
            end
            RD0, RD1: freeze_signal = 1'b1;
            FILL: begin
                if (MEM_R_EN) Data_out = word_sel ? fill_word1 : fill_word0;
            end
            WR: freeze_signal = !sram_ready;
            default: freeze_signal = 1'b0;
        endcase
    end

    // SRAM request outputs are registered and set up on the edge that enters each state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            valid0       <= '0;
            valid1       <= '0;
            lru          <= '0;
            sram_r_en    <= 1'b0;
            sram_w_en    <= 1'b0;
            sram_address <= '0;
            sram_wdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MEM_W_EN) begin
                        state        <= WR;
                        sram_w_en    <= 1'b1;
                        sram_address <= Data_address;
                        sram_wdata   <= Data_in;
                    end else if (MEM_R_EN) begin
                        if (hit) begin
                            lru[index] <= hit_way;
                        end else begin
                            state        <= RD0;
                            sram_r_en    <= 1'b1;
                            sram_address <= line_base;
                        end
                    end
                end
                RD0: begin
                    if (sram_ready) begin
                        fill_word0   <= sram_rdata;
                        sram_address <= line_base + 32'd4;
                        state        <= RD1;
                    end
                end
                RD1: begin
                    if (sram_ready) begin
                        fill_word1   <= sram_rdata;
                        sram_r_en    <= 1'b0;
                        sram_address <= '0;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (victim) valid1[index] <= 1'b1;
                    else        valid0[index] <= 1'b1;
                    lru[index] <= victim;
                    state      <= IDLE;
                end
                WR: begin
                    if (sram_ready) begin
                        if (hit) lru[index] <= hit_way;
                        sram_w_en    <= 1'b0;
                        sram_address <= '0;
                        sram_wdata   <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone decide whether they count.
    always_ff @(posedge clk) begin
        if (rst && state == FILL) begin
            tag_mem[victim][index] <= tag;
            w0_mem[victim][index]  <= fill_word0;
            w1_mem[victim][index]  <= fill_word1;
        end else if (rst && state == WR && sram_ready && hit) begin
            if (word_sel) w1_mem[hit_way][index] <= Data_in;
            else          w0_mem[hit_way][index] <= Data_in;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a fixed-latency SRAM responder.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] Data_address;
    logic [31:0] Data_in;
    logic [31:0] Data_out;
    logic        freeze_signal;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'hBAD0_0000;
    logic        sram_ready = 1'b0;

    int assertCount = 0;
    int failCount = 0;
    int waitCnt = 0;
    int rdCount = 0;
    int wrCount = 0;
    logic [31:0] rdAddr [$];
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic [31:0] memStore [logic [31:0]];

    dcache_controller dut (
        .clk           (clk),
        .rst           (rst),
        .MEM_R_EN      (MEM_R_EN),
        .MEM_W_EN      (MEM_W_EN),
        .Data_address  (Data_address),
        .Data_in       (Data_in),
        .Data_out      (Data_out),
        .freeze_signal (freeze_signal),
        .sram_r_en     (sram_r_en),
        .sram_w_en     (sram_w_en),
        .sram_address  (sram_address),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .sram_ready    (sram_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        if (memStore.exists(addr)) return memStore[addr];
        return {16'hC0DE, addr[15:0]};
    endfunction

    // SRAM answers every request on the third falling edge; rdata is garbage otherwise.
    always @(negedge clk) begin
        sram_ready = 1'b0;
        sram_rdata = 32'hBAD0_0000;
        if (sram_r_en && sram_w_en) checkOutput("sram_excl", 32'd1, 32'd0);
        if (sram_r_en || sram_w_en) begin
            if (waitCnt == 2) begin
                waitCnt = 0;
                sram_ready = 1'b1;
                if (sram_w_en) begin
                    memStore[sram_address] = sram_wdata;
                    wrAddr = sram_address;
                    wrData = sram_wdata;
                    wrCount++;
                end else begin
                    sram_rdata = modelRead(sram_address);
                    rdAddr.push_back(sram_address);
                    rdCount++;
                end
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
        MEM_R_EN = r;
        MEM_W_EN = w;
        Data_address = addr;
        Data_in = data;
    endtask

    task automatic doRead(input logic [31:0] addr, input logic expHit, input logic [31:0] expData,
                          input logic [31:0] expLine, input string tag);
        int cyc;
        int rd0;
        @(posedge clk); #1;
        rd0 = rdCount;
        rdAddr.delete();
        applyStimulus(1'b1, 1'b0, addr, 32'd0);
        #1;
        checkOutput({tag, "_hit"}, {31'd0, !freeze_signal}, {31'd0, expHit});
        cyc = 0;
        while (freeze_signal && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_unfrz"}, {31'd0, freeze_signal}, 32'd0);
        checkOutput({tag, "_data"}, Data_out, expData);
        checkOutput({tag, "_nrd"}, rdCount - rd0, expHit ? 32'd0 : 32'd2);
        if (!expHit && rdAddr.size() == 2) begin
            checkOutput({tag, "_a0"}, rdAddr[0], expLine);
            checkOutput({tag, "_a1"}, rdAddr[1], expLine + 32'd4);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        checkOutput({tag, "_idle_addr"}, sram_address, 32'd0);
        checkOutput({tag, "_idle_dout"}, Data_out, 32'd0);
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input string tag);
        int cyc;
        int wr0;
        @(posedge clk); #1;
        wr0 = wrCount;
        applyStimulus(1'b0, 1'b1, addr, data);
        #1;
        checkOutput({tag, "_frz"}, {31'd0, freeze_signal}, 32'd1);
        cyc = 0;
        while (freeze_signal && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_unfrz"}, {31'd0, freeze_signal}, 32'd0);
        checkOutput({tag, "_rdy"}, {31'd0, sram_ready}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        checkOutput({tag, "_nwr"}, wrCount - wr0, 32'd1);
        checkOutput({tag, "_waddr"}, wrAddr, addr);
        checkOutput({tag, "_wdata"}, wrData, data);
        checkOutput({tag, "_wen_off"}, {31'd0, sram_w_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int rd0;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_frz", {31'd0, freeze_signal}, 32'd0);
        checkOutput("rst_ren", {31'd0, sram_r_en}, 32'd0);
        checkOutput("rst_wen", {31'd0, sram_w_en}, 32'd0);
        checkOutput("rst_dout", Data_out, 32'd0);
        rst = 1'b1;

        // Cold miss, then the other word of the same line hits.
        doRead(32'd1028, 1'b0, 32'hC0DE_0404, 32'd1024, "t1");
        doRead(32'd1024, 1'b1, 32'hC0DE_0400, 32'd1024, "t2");

        // Set 0 replacement: 2048 evicts 1536, the least recently used way.
        doRead(32'd1024, 1'b1, 32'hC0DE_0400, 32'd1024, "t3a");
        doRead(32'd1536, 1'b0, 32'hC0DE_0600, 32'd1536, "t3b");
        doRead(32'd1024, 1'b1, 32'hC0DE_0400, 32'd1024, "t3c");
        doRead(32'd2048, 1'b0, 32'hC0DE_0800, 32'd2048, "t3d");
        doRead(32'd1024, 1'b1, 32'hC0DE_0400, 32'd1024, "t3e");
        doRead(32'd1536, 1'b0, 32'hC0DE_0600, 32'd1536, "t3f");

        doWrite(32'd1028, 32'hDEAD_BEEF, "t4w");
        doRead(32'd1028, 1'b1, 32'hDEAD_BEEF, 32'd1024, "t4r");

        doWrite(32'd4096, 32'h1234_5678, "t5w");
        doRead(32'd4096, 1'b0, 32'h1234_5678, 32'd4096, "t5r");

        // Reset lands while the second word of a miss is outstanding.
        @(posedge clk); #1;
        rd0 = rdCount;
        applyStimulus(1'b1, 1'b0, 32'd1100, 32'd0);
        cyc = 0;
        while (rdCount == rd0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("t6_rd1_ren", {31'd0, sram_r_en}, 32'd1);
        checkOutput("t6_rd1_addr", sram_address, 32'd1100);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        checkOutput("t6_ren", {31'd0, sram_r_en}, 32'd0);
        checkOutput("t6_wen", {31'd0, sram_w_en}, 32'd0);
        checkOutput("t6_frz", {31'd0, freeze_signal}, 32'd0);
        checkOutput("t6_dout", Data_out, 32'd0);
        rst = 1'b1;
        doRead(32'd1100, 1'b0, 32'hC0DE_044C, 32'd1096, "t6r");
        doRead(32'd1024, 1'b0, 32'hC0DE_0400, 32'd1024, "t6c");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
